// File: rtl/paddle_pkg.sv
// Shared paddle constants: FSM encoding, play-field geometry and default position limits.
// Imported by the paddle controller, mover and renderer.
package paddle_pkg;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_INC  = 2'd1;
  localparam logic [1:0] ST_DEC  = 2'd2;

  typedef enum logic [1:0] {
    StHold = ST_HOLD,
    StInc  = ST_INC,
    StDec  = ST_DEC
  } state_e;

  localparam logic [9:0] FIELD_H  = 10'd480;
  localparam logic [9:0] PADDLE_H = 10'd72;

  localparam logic [9:0] PY_MIN_DEF  = 10'd8;
  localparam logic [9:0] PY_MAX_DEF  = FIELD_H - PADDLE_H;
  localparam logic [9:0] PY_INIT_DEF = 10'd208;

  localparam logic [3:0] SPD_MIN_DEF    = 4'd1;
  localparam logic [3:0] SPD_MAX_DEF    = 4'd4;
  localparam logic [3:0] RAMP_TICKS_DEF = 4'd8;

  // Active-low request pair; both low is the controller's reset value and must not move.
  function automatic state_e decode_req(input logic p, input logic m);
    if (!p && m) return StInc;
    if (p && !m) return StDec;
    return StHold;
  endfunction

endpackage

// File: rtl/paddle_if.sv
// Request/position bundle between the paddle controller (master) and the paddle mover (slave).
interface paddle_if;

  logic       en;
  logic       p;
  logic       m;
  logic       recentre;
  logic [9:0] py;
  logic       moving;
  logic       at_min;
  logic       at_max;

  modport master (
    output en, p, m, recentre,
    input  py, moving, at_min, at_max
  );

  modport slave (
    input  en, p, m, recentre,
    output py, moving, at_min, at_max
  );

endinterface

// File: rtl/speed_ramp.sv
// Ramp counter and saturating speed; step is the move size for the current en tick.
module speed_ramp
  import paddle_pkg::*;
#(
  parameter logic [3:0] SPD_MIN    = SPD_MIN_DEF,
  parameter logic [3:0] SPD_MAX    = SPD_MAX_DEF,
  parameter logic [3:0] RAMP_TICKS = RAMP_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       entry,
  input  logic       hold_or_clamp,
  output logic [3:0] step
);

  logic [3:0] spd_q, spd_d;
  logic [3:0] ramp_q, ramp_d;

  assign step = entry ? SPD_MIN : spd_q;

  always_comb begin
    spd_d  = spd_q;
    ramp_d = ramp_q;
    if (hold_or_clamp) begin
      spd_d  = SPD_MIN;
      ramp_d = 4'd0;
    end else if (entry) begin
      spd_d  = SPD_MIN;
      ramp_d = 4'd1;
    end else begin
      ramp_d = ramp_q + 4'd1;
      if (ramp_d == RAMP_TICKS) begin
        ramp_d = 4'd0;
        spd_d  = (spd_q < SPD_MAX) ? spd_q + 4'd1 : SPD_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      spd_q  <= SPD_MIN;
      ramp_q <= 4'd0;
    end else if (en) begin
      spd_q  <= spd_d;
      ramp_q <= ramp_d;
    end
  end

endmodule

// File: rtl/paddle_mover.sv
// Paddle Y position stage: decodes the plus/minus request, ramps speed while held and clamps
// at the field limits. All outputs are registered.
module paddle_mover
  import paddle_pkg::*;
#(
  parameter logic [9:0] PY_MIN     = PY_MIN_DEF,
  parameter logic [9:0] PY_MAX     = PY_MAX_DEF,
  parameter logic [9:0] PY_INIT    = PY_INIT_DEF,
  parameter logic [3:0] SPD_MIN    = SPD_MIN_DEF,
  parameter logic [3:0] SPD_MAX    = SPD_MAX_DEF,
  parameter logic [3:0] RAMP_TICKS = RAMP_TICKS_DEF
) (
  input logic     clk,
  input logic     rst,
  paddle_if.slave bus
);

  state_e      state_q, state_d;
  logic [9:0]  py_q, py_d;
  logic        moving_q, at_min_q, at_max_q;
  logic [3:0]  step;
  logic [10:0] sum;
  logic        entry, clamp, hold_or_clamp, ramp_rst;

  assign state_d       = decode_req(bus.p, bus.m);
  assign entry         = (state_d != state_q) || (state_q == StHold);
  assign sum           = {1'b0, py_q} + {7'd0, step};
  assign hold_or_clamp = (state_d == StHold) || clamp;
  // Re-centre must also reset the ramp, and it ignores en just like rst.
  assign ramp_rst      = rst & ~bus.recentre;

  speed_ramp #(
    .SPD_MIN   (SPD_MIN),
    .SPD_MAX   (SPD_MAX),
    .RAMP_TICKS(RAMP_TICKS)
  ) u_speed_ramp (
    .clk          (clk),
    .rst          (ramp_rst),
    .en           (bus.en),
    .entry        (entry),
    .hold_or_clamp(hold_or_clamp),
    .step         (step)
  );

  // 11-bit compares so neither direction can wrap past the 10-bit range.
  always_comb begin
    py_d  = py_q;
    clamp = 1'b0;
    unique case (state_d)
      StInc: begin
        if (sum > {1'b0, PY_MAX}) begin
          py_d  = PY_MAX;
          clamp = 1'b1;
        end else begin
          py_d = sum[9:0];
        end
      end
      StDec: begin
        if ({1'b0, py_q} < ({1'b0, PY_MIN} + {7'd0, step})) begin
          py_d  = PY_MIN;
          clamp = 1'b1;
        end else begin
          py_d = py_q - {6'd0, step};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.recentre) begin
      state_q  <= StHold;
      py_q     <= PY_INIT;
      moving_q <= 1'b0;
      at_min_q <= (PY_INIT == PY_MIN);
      at_max_q <= (PY_INIT == PY_MAX);
    end else if (bus.en) begin
      state_q  <= state_d;
      py_q     <= py_d;
      moving_q <= (state_d != StHold);
      at_min_q <= (py_d == PY_MIN);
      at_max_q <= (py_d == PY_MAX);
    end
  end

  assign bus.py     = py_q;
  assign bus.moving = moving_q;
  assign bus.at_min = at_min_q;
  assign bus.at_max = at_max_q;

endmodule

// File: tb/tb_paddle_mover.sv
// Directed + random bench for paddle_mover; a behavioural model queues expected outputs per tick.
module tb_paddle_mover;

  logic clk = 1'b0;
  logic rst;

  paddle_if bus ();

  paddle_mover dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] py;
    logic       moving;
    logic       at_min;
    logic       at_max;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: dir 0 = hold, 1 = up (INC), 2 = down (DEC)
  int m_py   = 208;
  int m_spd  = 1;
  int m_ramp = 0;
  int m_dir  = 0;

  function automatic void model(input logic r, input logic rc, input logic e,
                                input logic pp, input logic mm);
    int req;
    int stp;
    bit first;
    bit lim;
    if (!r || rc) begin
      m_py = 208; m_dir = 0; m_spd = 1; m_ramp = 0;
      return;
    end
    if (!e) return;
    if (pp == 1'b0 && mm == 1'b1) req = 1;
    else if (pp == 1'b1 && mm == 1'b0) req = 2;
    else req = 0;
    if (req == 0) begin
      m_spd = 1; m_ramp = 0; m_dir = 0;
      return;
    end
    first = (req != m_dir) || (m_dir == 0);
    stp   = first ? 1 : m_spd;
    lim   = 1'b0;
    if (req == 1) begin
      if (m_py + stp > 408) begin m_py = 408; lim = 1'b1; end
      else m_py = m_py + stp;
    end else begin
      if (m_py - stp < 8) begin m_py = 8; lim = 1'b1; end
      else m_py = m_py - stp;
    end
    if (lim) begin
      m_spd = 1; m_ramp = 0;
    end else if (first) begin
      m_spd = 1; m_ramp = 1;
    end else begin
      m_ramp++;
      if (m_ramp == 8) begin
        m_ramp = 0;
        if (m_spd < 4) m_spd++;
      end
    end
    m_dir = req;
  endfunction

  task automatic tick(input logic r, input logic rc, input logic e, input logic pp,
                      input logic mm);
    exp_t ex;
    exp_t got;
    rst          = r;
    bus.recentre = rc;
    bus.en       = e;
    bus.p        = pp;
    bus.m        = mm;
    model(r, rc, e, pp, mm);
    ex.py     = 10'(m_py);
    ex.moving = (m_dir != 0);
    ex.at_min = (m_py == 8);
    ex.at_max = (m_py == 408);
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    ex  = exp_q.pop_front();
    got = {bus.py, bus.moving, bus.at_min, bus.at_max};
    n_tests++;
    assert (got === ex) else begin
      n_fail++;
      $error("FAIL tick: got py=%0d mv=%b min=%b max=%b, need py=%0d mv=%b min=%b max=%b",
             got.py, got.moving, got.at_min, got.at_max,
             ex.py, ex.moving, ex.at_min, ex.at_max);
    end
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d, need %0d", tag, obs, expv);
    end
  endtask

  task automatic inc(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic dec(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  int ramp_exp[9] = '{209, 210, 211, 212, 213, 214, 215, 216, 218};

  initial begin
    rst = 1'b0; bus.en = 1'b0; bus.p = 1'b1; bus.m = 1'b1; bus.recentre = 1'b0;

    // Reset held two cycles
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("reset_py", int'(bus.py), 208);
    check("reset_moving", int'(bus.moving), 0);
    check("reset_at_min", int'(bus.at_min), 0);
    check("reset_at_max", int'(bus.at_max), 0);

    // Both requests low must not move
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("both_low_py", int'(bus.py), 208);
    check("both_low_moving", int'(bus.moving), 0);

    // Ramp: step 1 for eight ticks, then 2
    for (int i = 0; i < 9; i++) begin
      inc(1);
      check("ramp_py", int'(bus.py), ramp_exp[i]);
    end
    inc(23);
    check("ramp_32_py", int'(bus.py), 288);
    inc(1);
    check("ramp_sat_py", int'(bus.py), 292);

    // Upper clamp from 406 at speed 4
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("recentre_py", int'(bus.py), 208);
    inc(2);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    inc(61);
    check("pre_clamp_py", int'(bus.py), 406);
    inc(1);
    check("clamp_hi_py", int'(bus.py), 408);
    check("clamp_hi_at_max", int'(bus.at_max), 1);
    inc(3);
    check("clamp_hi_hold_py", int'(bus.py), 408);
    check("clamp_hi_moving", int'(bus.moving), 1);

    // Lower clamp with no wrap
    dec(120);
    check("clamp_lo_py", int'(bus.py), 8);
    check("clamp_lo_at_min", int'(bus.at_min), 1);
    check("clamp_lo_moving", int'(bus.moving), 1);

    // Reversal at speed 3 restarts at step 1; en=0 holds
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    inc(17);
    check("rev_pre_py", int'(bus.py), 235);
    dec(1);
    check("rev_py", int'(bus.py), 234);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("en_gate_py", int'(bus.py), 234);

    // Re-centre mid-move with en=0, then rst together with recentre
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    inc(25);
    check("mid_move_py", int'(bus.py), 260);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rc_mid_py", int'(bus.py), 208);
    check("rc_mid_moving", int'(bus.moving), 0);
    inc(1);
    check("rc_spd_py", int'(bus.py), 209);
    inc(3);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_rc_py", int'(bus.py), 208);
    check("rst_rc_moving", int'(bus.moving), 0);

    // Random mix against the model
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_mover.md
Name: paddle_mover

Overview:
Paddle position stage directly downstream of the automatic paddle controller. It consumes the active-low plus/minus request pair and produces the registered 10-bit paddle Y coordinate `py`, which feeds back to the controller and to the renderer. It applies a speed ramp while a direction is held, clamps at the play-field limits, and supports a synchronous re-centre.

Parameters:
- PY_MIN, 10'd8: lowest legal `py`.
- PY_MAX, 10'd408: highest legal `py` (field bottom minus paddle height).
- PY_INIT, 10'd208: reset and re-centre position.
- SPD_MIN, 4'd1: step size on the first tick of a movement.
- SPD_MAX, 4'd4: saturation step size.
- RAMP_TICKS, 4'd8: consecutive same-direction ticks per speed increment.
- Legal range: PY_MIN<=PY_INIT<=PY_MAX; 1<=SPD_MIN<=SPD_MAX; PY_MAX+SPD_MAX<1024.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  movement tick enable; registers update only when en=1, except rst and recentre.
- p  in  1  active-low plus request (increment py).
- m  in  1  active-low minus request (decrement py).
- recentre  in  1  synchronous re-centre request, active-high.
- py  out  10  registered paddle Y position.
- moving  out  1  registered; 1 when state is not HOLD.
- at_min  out  1  registered; py==PY_MIN.
- at_max  out  1  registered; py==PY_MAX.

Behaviour:
- Reset (rst=0 at a clk edge): py=PY_INIT, state=HOLD, spd=SPD_MIN, ramp=0, moving=0, at_min=(PY_INIT==PY_MIN), at_max=(PY_INIT==PY_MAX). rst has priority over everything.
- Re-centre: recentre=1 at a clk edge (en ignored) has the same effect as reset. It has priority over movement.
- en=0: all registers hold.
- Request decode, per en tick:
  - p=0,m=1 -> INC.
  - p=1,m=0 -> DEC.
  - p=1,m=1 or p=0,m=0 -> HOLD. Both low is the controller's reset value and must not move the paddle.
- FSM states are HOLD, INC, DEC. The next state equals the decoded request on every en tick; any-to-any transition is legal.
- Step size for a tick:
  - Entry tick (new state differs from state_ff, or state_ff was HOLD): step=SPD_MIN, ramp becomes 1, spd becomes SPD_MIN.
  - Continuation tick: step=spd_ff, ramp=ramp_ff+1. When ramp reaches RAMP_TICKS, ramp=0 and spd=min(spd_ff+1,SPD_MAX).
- Position update:
  - INC: py=min(py+step, PY_MAX), computed at 11 bits, no wrap.
  - DEC: py = (py<PY_MIN+step) ? PY_MIN : py-step. No underflow.
  - HOLD: py unchanged, spd=SPD_MIN, ramp=0.
- Clamping: if a step is clamped, or the paddle is already at the limit in the requested direction, py holds the limit, spd=SPD_MIN and ramp=0. The state stays INC/DEC, so moving=1.
- Latency: a request sampled at en tick k is reflected in py, moving, at_min and at_max after that same clk edge (1 cycle). There is no combinational path from p/m to any output.
- Direction reversal (INC->DEC in consecutive ticks) is treated as an entry: step=SPD_MIN.

Decomposition:
- Package paddle_pkg:
  - state encoding constants ST_HOLD=2'd0, ST_INC=2'd1, ST_DEC=2'd2;
  - field constants FIELD_H=10'd480, PADDLE_H=10'd72;
  - default PY_MIN/PY_MAX/PY_INIT values, shared with the controller and renderer.
- One sub-module, speed_ramp: ramp counter and saturating speed. Inputs: clk, rst, en, entry, hold_or_clamp. Outputs: step[3:0]. paddle_mover keeps the FSM, clamp arithmetic and flags.

Test Plan:
- Reset: rst=0 for 2 cycles -> py=208, moving=0, at_min=0, at_max=0. p=0,m=0 with en=1 afterwards -> py stays 208.
- Ramp: from py=208, p=0,m=1 for 9 en ticks -> py=209..216 on ticks 1-8 (step 1), 218 on tick 9 (step 2). After 32 held ticks, step is saturated at 4.
- Upper clamp: py=406, spd=4, INC tick -> py=408, at_max=1, spd reset to 1. Further INC ticks -> py stays 408, moving=1.
- Lower clamp: py=10, DEC held at spd=4 -> py=8, at_min=1, no wrap to high values.
- Reversal and en gating: INC at spd=3 then DEC -> first DEC step=1. en=0 with p=0,m=1 -> py unchanged.
- Re-centre mid-move: recentre=1 while INC at spd=4, en=0 -> next edge py=208, moving=0, spd=1. rst=0 asserted together with recentre also yields the reset values.
